// File: rtl/moore_table_fsm.sv
// Table-programmable Moore FSM: run-time next-state/output tables, step enable, preload, step counter.
// Optional range check on transitions via MOORE_RANGE_CHK_EN (err tied 0 when undefined).
module moore_table_fsm #(
    parameter int IN_W       = 2,
    parameter int STATE_W    = 3,
    parameter int NUM_STATES = 8,
    parameter int OUT_W      = 1,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IN_W-1:0]    sw_in,
    input  logic               ctrl_in,
    input  logic               load_in,
    input  logic [STATE_W-1:0] state_in,
    input  logic               cfg_nx_we,
    input  logic [STATE_W-1:0] cfg_st,
    input  logic [IN_W-1:0]    cfg_sym,
    input  logic [STATE_W-1:0] cfg_nx,
    input  logic               cfg_out_we,
    input  logic [OUT_W-1:0]   cfg_out,
    output logic [STATE_W-1:0] state,
    output logic [OUT_W-1:0]   out,
    output logic               state_chg,
    output logic [CNT_W-1:0]   step_cnt,
    output logic               err
);

    localparam int NS   = 2 ** STATE_W;
    localparam int NSYM = 2 ** IN_W;
    localparam logic [STATE_W:0] NUM_ST_L = (STATE_W + 1)'(NUM_STATES);
`ifdef MOORE_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic [STATE_W-1:0] nx_tbl_q [NS][NSYM];
    logic [OUT_W-1:0]   ot_tbl_q [NS];

    logic [STATE_W-1:0] state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               chg_q, chg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               take;
    logic               oor;
    logic [STATE_W-1:0] tgt;

    // Tables are read combinationally below, so same-edge writes are seen only next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                ot_tbl_q[s] <= '0;
                for (int x = 0; x < NSYM; x++) begin
                    nx_tbl_q[s][x] <= STATE_W'(s);
                end
            end
        end else begin
            if (cfg_nx_we) begin
                nx_tbl_q[cfg_st][cfg_sym] <= cfg_nx;
            end
            if (cfg_out_we) begin
                ot_tbl_q[cfg_st] <= cfg_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            out_q   <= '0;
            chg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        take    = load_in | ctrl_in;
        tgt     = load_in ? state_in : nx_tbl_q[state_q][sw_in];
        oor     = RANGE_CHK && take && ({1'b0, tgt} >= NUM_ST_L);
        state_d = state_q;
        if (take) begin
            state_d = oor ? '0 : tgt;
        end
    end

    always_comb begin
        out_d = take ? ot_tbl_q[state_d] : out_q;
        chg_d = oor ? (state_q != '0) : (ctrl_in & ~load_in & (state_d != state_q));
        cnt_d = cnt_q;
        if (load_in) begin
            cnt_d = '0;
        end else if (ctrl_in && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef MOORE_RANGE_CHK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= oor;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign state     = state_q;
    assign out       = out_q;
    assign state_chg = chg_q;
    assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_moore_table_fsm.sv
// Scoreboard bench for moore_table_fsm: directed plan then random traffic against a table model.
module tb_moore_table_fsm;
    localparam int IN_W = 2, STATE_W = 3, NUM_STATES = 6, OUT_W = 2, CNT_W = 2;
    localparam int CMAX = 3;
`ifdef MOORE_RANGE_CHK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0, ctrl_in = 1'b0, load_in = 1'b0, cfg_nx_we = 1'b0, cfg_out_we = 1'b0;
    logic [IN_W-1:0] sw_in = '0, cfg_sym = '0;
    logic [STATE_W-1:0] state_in = '0, cfg_st = '0, cfg_nx = '0;
    logic [OUT_W-1:0] cfg_out = '0;
    logic [STATE_W-1:0] state;
    logic [OUT_W-1:0] out;
    logic state_chg, err;
    logic [CNT_W-1:0] step_cnt;

    moore_table_fsm #(.IN_W(IN_W), .STATE_W(STATE_W), .NUM_STATES(NUM_STATES),
                      .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in), .ctrl_in(ctrl_in), .load_in(load_in),
        .state_in(state_in), .cfg_nx_we(cfg_nx_we), .cfg_st(cfg_st), .cfg_sym(cfg_sym),
        .cfg_nx(cfg_nx), .cfg_out_we(cfg_out_we), .cfg_out(cfg_out),
        .state(state), .out(out), .state_chg(state_chg), .step_cnt(step_cnt), .err(err));

    always #5 clk = ~clk;

    typedef struct { int st; int o; int chg; int cnt; int err; } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0, n_bad = 0;

    int m_nx [8][4];
    int m_ot [8];
    int m_st = 0, m_out = 0, m_chg = 0, m_cnt = 0, m_err = 0;

    // Reference: abstract table semantics evaluated on the inputs present at the edge.
    task automatic model_edge();
        int tgt;
        bit move;
        exp_t e;
        if (reset) begin
            m_st = 0; m_out = 0; m_chg = 0; m_cnt = 0; m_err = 0;
            for (int s = 0; s < 8; s++) begin
                m_ot[s] = 0;
                for (int x = 0; x < 4; x++) m_nx[s][x] = s;
            end
        end else begin
            m_chg = 0; m_err = 0; move = 0; tgt = 0;
            if (load_in) begin
                tgt = int'(state_in); m_cnt = 0; move = 1;
            end else if (ctrl_in) begin
                tgt = m_nx[m_st][int'(sw_in)];
                m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
                move = 1;
            end
            if (move) begin
                if (RC && tgt >= NUM_STATES) begin
                    m_err = 1; m_chg = (m_st != 0) ? 1 : 0; tgt = 0;
                end else begin
                    m_chg = (!load_in && tgt != m_st) ? 1 : 0;
                end
                m_out = m_ot[tgt];
                m_st  = tgt;
            end
            if (cfg_nx_we) m_nx[int'(cfg_st)][int'(cfg_sym)] = int'(cfg_nx);
            if (cfg_out_we) m_ot[int'(cfg_st)] = int'(cfg_out);
        end
        e.st = m_st; e.o = m_out; e.chg = m_chg; e.cnt = m_cnt; e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state", int'(state), e.st);
                chk("out", int'(out), e.o);
                chk("state_chg", int'(state_chg), e.chg);
                chk("step_cnt", int'(step_cnt), e.cnt);
                chk("err", int'(err), e.err);
            end
        end
    end

    // Called at a negedge: drive, take one edge, record expectation, return at next negedge.
    task automatic drv(input int r, input int ld, input int ct, input int sw, input int sin,
                       input int nwe, input int cst, input int csym, input int cnx,
                       input int owe, input int cout);
        reset = r[0]; load_in = ld[0]; ctrl_in = ct[0]; sw_in = sw[IN_W-1:0];
        state_in = sin[STATE_W-1:0]; cfg_nx_we = nwe[0]; cfg_st = cst[STATE_W-1:0];
        cfg_sym = csym[IN_W-1:0]; cfg_nx = cnx[STATE_W-1:0]; cfg_out_we = owe[0];
        cfg_out = cout[OUT_W-1:0];
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic step(input int sw);         drv(0, 0, 1, sw, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic idle(input int sw);         drv(0, 0, 0, sw, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic load(input int s);          drv(0, 1, 0, 0, s, 0, 0, 0, 0, 0, 0); endtask
    task automatic wnx(input int s, input int x, input int v); drv(0, 0, 0, 0, 0, 1, s, x, v, 0, 0); endtask
    task automatic wot(input int s, input int v);              drv(0, 0, 0, 0, 0, 0, s, 0, 0, 1, v); endtask

    initial begin
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 1, 3, 5, 1, 0, 0, 3, 1, 2);
        step($urandom_range(0, 3));
        // Legacy two-state switch machine.
        wnx(0, 1, 1); wnx(0, 2, 1); wnx(0, 3, 1); wnx(0, 0, 0);
        wnx(1, 0, 1); wnx(1, 2, 1); wnx(1, 1, 0); wnx(1, 3, 0);
        wot(1, 1);
        step(2); step(0); step(3);
        for (int i = 0; i < 5; i++) idle(i % 4);
        wot(5, 1);
        drv(0, 1, 1, 2, 5, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(i % 4);
        load(0);
        drv(0, 0, 1, 0, 0, 1, 0, 0, 4, 0, 0);
        step(0);
        load(7);
        idle(0);
        drv(0, 1, 0, 0, 6, 1, 6, 1, 2, 1, 3);
        step(1);
        for (int i = 0; i < 600; i++) begin
            drv(($urandom_range(0, 59) == 0) ? 1 : 0,
                ($urandom_range(0, 9) == 0) ? 1 : 0,
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                $urandom_range(0, 3), $urandom_range(0, 7),
                ($urandom_range(0, 2) == 0) ? 1 : 0,
                $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
                ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 3));
        end
        idle(0);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/moore_table_fsm.md
Name: moore_table_fsm

Overview:
- Parametrised, table-programmable Moore state machine. It is the successor to the fixed 2-state, 2-bit-input switch FSM.
- State count, input width and output width are generic. Next-state and output tables are written at run time through a config port.
- Keeps the step-enable (ctrl_in) and state-preload (state_in) semantics. Adds a step counter and a state-change pulse.
- Sits between debounced switch inputs and LED/control outputs in the lab designs.

Parameters:
- IN_W, 2, width of sw_in; each state has 2**IN_W successor entries
- STATE_W, 3, width of the state register; tables hold 2**STATE_W states
- NUM_STATES, 8, legal state count, 1..2**STATE_W
- OUT_W, 1, width of the Moore output
- CNT_W, 8, width of the step counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- sw_in  in  IN_W  input symbol sampled on each step
- ctrl_in  in  1  step enable; when 1, a transition is taken this edge
- load_in  in  1  preload request; state <= state_in
- state_in  in  STATE_W  preload value
- cfg_nx_we  in  1  write next-state table entry
- cfg_st  in  STATE_W  table state index
- cfg_sym  in  IN_W  table input-symbol index
- cfg_nx  in  STATE_W  next-state value written
- cfg_out_we  in  1  write output table entry at cfg_st
- cfg_out  in  OUT_W  output value written
- state  out  STATE_W  current state, registered
- out  out  OUT_W  Moore output, registered
- state_chg  out  1  one-cycle pulse when a step changes state
- step_cnt  out  CNT_W  saturating count of steps taken
- err  out  1  range-error pulse (optional feature; tied 0 otherwise)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); it is sampled only on the rising edge of clk.
- Tables: NX[s][x] is STATE_W bits, one entry per state s and symbol x; OT[s] is OUT_W bits.
- Reset values:
  - state=0, out=0, state_chg=0, step_cnt=0, err=0
  - NX[s][x]=s for all s,x (self-loop)
  - OT[s]=0 for all s
- Priority per edge: reset > load_in > ctrl_in. Config writes are independent of this priority and are ignored only during reset.
- Load: state<=state_in; out<=OT[state_in]; step_cnt<=0; state_chg<=0.
- Step (ctrl_in=1, load_in=0):
  - nx=NX[state][sw_in]; state<=nx; out<=OT[nx]
  - state_chg<=(nx!=state)
  - step_cnt<=step_cnt+1, saturating at 2**CNT_W-1 with no wrap
- Idle (ctrl_in=0, load_in=0): state, out and step_cnt hold; state_chg<=0.
- Latency: state and out update on the same edge that samples ctrl_in/sw_in. out always equals OT[state] as it stood at the last step or load.
- Config writes:
  - A write lands on the edge. Same-edge steps and loads read the pre-write table value (read-before-write).
  - cfg_nx_we and cfg_out_we may be asserted together.
  - Writing OT[state] does not change out until the next step or load.
- Indices >= NUM_STATES are legal table addresses; the range check applies only to state transitions (see optional feature).
- Reset asserted mid-run discards the state. Table contents also return to their defaults; software must reprogram after reset.
- Outputs must not go X after reset. The block has no initial blocks and no delays; preload is done only through load_in.

Optional Feature:
- Macro: MOORE_RANGE_CHK_EN.
- Defined: if a step or load targets a value >= NUM_STATES, state<=0 and out<=OT[0].
  - err pulses 1 for one cycle.
  - state_chg<=(state!=0).
  - For a step, step_cnt still increments; for a load, step_cnt still clears.
- Undefined: the out-of-range value is taken as-is and err is tied 0.

Test Plan:
- Reset, then step with any sw_in -> state=0, out=0, state_chg=0, step_cnt=1.
- Program the legacy 2-state machine: NX[0][1..3]=1, NX[0][0]=0, NX[1][0]=1, NX[1][2]=1, NX[1][1]=0, NX[1][3]=0, OT[1]=1.
  - Steps with sw_in=2,0,3 -> state 1,1,0; out 1,1,0; state_chg 1,0,1.
- ctrl_in=0 for 5 cycles while sw_in toggles -> state, out and step_cnt unchanged.
- load_in=1 and ctrl_in=1 on the same edge with state_in=5, OT[5]=1 -> state=5, out=1, step_cnt=0.
- CNT_W=2: 5 steps -> step_cnt=3 and holds. Same-edge write of NX[0][0]=4 while stepping from state 0 with sw_in=0 -> state=0 (old value); next step -> state=4.
- MOORE_RANGE_CHK_EN with NUM_STATES=6: load state_in=7 -> state=0, err=1 for one cycle. Without the macro, the same load -> state=7, err=0.
